// File: rtl/ov7670_stream_gen.sv
// ============================================================================
// Module      : ov7670_stream_gen
// Description : OV7670 output-side emulator. It turns RGB332 pixels into
//               vsync/href/RGB565 bytes. Define OV_PATTERN_EN to use internal
//               colour bars instead of px_data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_stream_gen #(
  parameter int H_ACTIVE     = 160,
  parameter int V_ACTIVE     = 120,
  parameter int H_BLANK      = 16,
  parameter int VSYNC_LINES  = 3,
  parameter int VBACK_LINES  = 17,
  parameter int VFRONT_LINES = 10,
  parameter int ADDR_W       = 15
) (
  input  logic              pclk,
  input  logic              in_reset,
  input  logic              en,
  input  logic [7:0]        px_data,
  output logic              px_rd,
  output logic [ADDR_W-1:0] px_addr,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        dout,
  output logic              frame_done,
  output logic              busy
);

  localparam int LINE_CYC = 2*H_ACTIVE + H_BLANK;
  localparam int COL_W    = $clog2(LINE_CYC);
  localparam int LINE_W   = $clog2(VSYNC_LINES + VBACK_LINES + V_ACTIVE + VFRONT_LINES + 1);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(LINE_CYC - 1);
  localparam logic [COL_W-1:0]  COL_PRE    = COL_W'(LINE_CYC - 2);
  localparam logic [COL_W-1:0]  COL_HREF   = COL_W'(2*H_ACTIVE);
  localparam logic [COL_W-1:0]  COL_RD_END = COL_W'(2*H_ACTIVE - 2);
  localparam logic [LINE_W-1:0] VS_LAST    = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VB_LAST    = LINE_W'(VBACK_LINES - 1);
  localparam logic [LINE_W-1:0] VA_LAST    = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VF_LAST    = LINE_W'(VFRONT_LINES - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(H_ACTIVE*V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [COL_W-1:0]    col, col_n;
  logic [LINE_W-1:0]   line, line_n, line_last;
  logic [7:0]          hold;
  logic [7:0]          pix;
  logic                href_n, rd_n, done_n;

  function automatic logic [7:0] hi_byte(input logic [7:0] p);
    return {p[7:5], p[7:6], p[4:2]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [7:0] p);
    return {p[4:2], p[1:0], p[1:0], p[1]};
  endfunction

  always_comb begin
    case (state)
      S_VSYNC:  line_last = VS_LAST;
      S_VBACK:  line_last = VB_LAST;
      S_ACTIVE: line_last = VA_LAST;
      default:  line_last = VF_LAST;
    endcase
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    line_n  = line;
    if (state == S_IDLE) begin
      if (en) state_n = S_VSYNC;
      col_n  = '0;
      line_n = '0;
    end else if (col == COL_LAST) begin
      col_n = '0;
      if (line == line_last) begin
        line_n = '0;
        case (state)
          S_VSYNC:  state_n = S_VBACK;
          S_VBACK:  state_n = S_ACTIVE;
          S_ACTIVE: state_n = S_VFRONT;
          S_VFRONT: state_n = en ? S_VSYNC : S_IDLE;
          default:  state_n = S_IDLE;
        endcase
      end else begin
        line_n = line + 1'b1;
      end
    end else begin
      col_n = col + 1'b1;
    end
  end

  // Outputs are derived from the next position so that, once registered,
  // they line up with the state/col they describe.
  always_comb begin
    href_n = (state_n == S_ACTIVE) && (col_n < COL_HREF);
    done_n = (state_n == S_VFRONT) && (line_n == VF_LAST) && (col_n == COL_LAST);
`ifdef OV_PATTERN_EN
    rd_n = 1'b0;
    case ((int'(col_n >> 1) * 8) / H_ACTIVE)
      0:       pix = 8'hFF;
      1:       pix = 8'hFC;
      2:       pix = 8'h1F;
      3:       pix = 8'h1C;
      4:       pix = 8'hE3;
      5:       pix = 8'hE0;
      6:       pix = 8'h03;
      default: pix = 8'h00;
    endcase
`else
    // In-line fetches cover pixels 1..H-1; pixel 0 of the next line is
    // fetched two cycles before href rises.
    rd_n = ((state_n == S_ACTIVE) && !col_n[0] && (col_n < COL_RD_END)) ||
           ((col_n == COL_PRE) &&
            (((state_n == S_VBACK) && (line_n == VB_LAST)) ||
             ((state_n == S_ACTIVE) && (line_n != VA_LAST))));
    pix  = px_data;
`endif
  end

  always_ff @(posedge pclk) begin
    if (in_reset) begin
      state      <= S_IDLE;
      col        <= '0;
      line       <= '0;
      hold       <= '0;
      px_rd      <= 1'b0;
      px_addr    <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      dout       <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      line       <= line_n;
      px_rd      <= rd_n;
      vsync      <= (state_n == S_VSYNC);
      href       <= href_n;
      frame_done <= done_n;
      busy       <= (state_n != S_IDLE);
      if (state_n == S_VSYNC)
        px_addr <= '0;
      else if (px_rd && (px_addr != PIX_LAST))
        px_addr <= px_addr + 1'b1;
      if (href_n && !col_n[0]) begin
        hold <= pix;
        dout <= hi_byte(pix);
      end else if (href_n) begin
        dout <= lo_byte(hold);
      end else begin
        dout <= '0;
      end
    end
  end

endmodule

`default_nettype wire
